instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 clock  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 imem_req  output  1  instruction-memory read request.
REQ-004 imem_addr  output  16  byte address of requested instruction; equals pc.
REQ-005 imem_ack  input  1  memory has data valid on imem_data this cycle.
REQ-006 imem_data  input  16  instruction word returned by memory.
REQ-007 stall  input  1  downstream cannot accept the issued instruction this cycle.
REQ-008 branch  input  1  branch control signal from the control decoder.
REQ-009 zero  input  1  ALU zero flag for the issued instruction.
REQ-010 instr  output  16  instruction register (IR) contents.
REQ-011 opcode  output  3  opcode presented to the control decoder.
REQ-012 instr_valid  output  1  instr/opcode are being executed this cycle.
REQ-013 pc  output  16  address of the instruction held in IR.

Function
REQ-014 The state machine SHALL have exactly the states IDLE, FETCH and ISSUE.
REQ-015 IDLE SHALL last one cycle after reset release, then move to FETCH.
REQ-016 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, held stable until imem_ack.
REQ-017 In FETCH with imem_ack=1, IR SHALL load imem_data at that edge and the state SHALL move to ISSUE; otherwise the state SHALL remain FETCH.
REQ-018 imem_ack SHALL be ignored outside FETCH, and imem_req SHALL be 0 outside FETCH.
REQ-019 In ISSUE with stall=0: instr_valid=1, opcode=IR[15:13], pc SHALL update at the edge, and the state SHALL move to FETCH.
REQ-020 In ISSUE with stall=1: instr_valid=0, opcode=3'd2 (bubble), pc and IR SHALL hold, and the state SHALL remain ISSUE.
REQ-021 In every state other than unstalled ISSUE, opcode SHALL be 3'd2; the decoder's default case deasserts all write enables.
REQ-022 Next pc SHALL be pc + (sign-extended IR[12:6] shifted left 1) when branch=1 and zero=1; otherwise pc + 2.
REQ-023 branch and zero SHALL be sampled only in unstalled ISSUE.
REQ-024 pc arithmetic SHALL be 16-bit modulo 2^16: 16'hFFFE + 2 yields 16'h0000, and the branch target wraps the same way.
REQ-025 pc[0] SHALL always be 0.
REQ-026 Throughput SHALL be one instruction per 2 cycles with zero-wait memory (ack in the first FETCH cycle).

Reset
REQ-027 While reset=0: state=IDLE, pc=16'h0000, IR=16'h4000, imem_req=0, instr_valid=0, opcode=3'd2.
REQ-028 Reset asserted mid-FETCH or mid-ISSUE SHALL abort immediately and asynchronously; a pending ack SHALL be discarded.

Structure
REQ-029 Package leglite_pkg SHALL hold: opcode constants (ADD=0, SUB=1, BUBBLE=2, LD=3, ST=4, CBZ=5, ADDI=6, ANDI=7), the fetch-state enum, RESET_PC=16'h0000, and the field positions for opcode [15:13] and branch offset [12:6].
REQ-030 Next-pc computation SHALL be the single combinational sub-module pc_next (inputs pc, offset, take_branch; output next pc).

Verification
REQ-031 Reset release, ack in the same cycle as req, stall=0, memory returning 16'h0000 -> imem_addr sequence 0,2,4,6 with req on alternate cycles; opcode 0 with instr_valid=1 once per 2 cycles.
REQ-032 Ack delayed 3 cycles -> req and imem_addr=pc held for 4 cycles; opcode=2 throughout; IR loads only on the ack edge.
REQ-033 IR=16'hBFC0 (CBZ, offset -1) at pc=16'h0010, branch=1, zero=1 -> next imem_addr=16'h000E; same with zero=0 -> 16'h0012.
REQ-034 stall=1 for 2 cycles during ISSUE -> opcode=2, instr_valid=0, pc held; on release opcode=IR[15:13] for exactly one cycle.
REQ-035 pc=16'hFFFE, no branch -> next imem_addr=16'h0000.
REQ-036 reset asserted during FETCH with ack pending -> outputs go to reset values without waiting for a clock edge; after release the first request is to address 16'h0000.

Source files
------------

// File: rtl/leglite_pkg.sv
// Shared constants, opcode encodings and fetch-state type for the leglite fetch unit.
package leglite_pkg;

  localparam int unsigned XLEN    = 16;
  localparam int unsigned OPC_W   = 3;
  localparam int unsigned OFF_W   = 7;
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 13;
  localparam int unsigned OFF_MSB = 12;
  localparam int unsigned OFF_LSB = 6;

  localparam logic [XLEN-1:0] RESET_PC = 16'h0000;
  localparam logic [XLEN-1:0] RESET_IR = 16'h4000;

  localparam logic [OPC_W-1:0] OP_ADD    = 3'd0;
  localparam logic [OPC_W-1:0] OP_SUB    = 3'd1;
  localparam logic [OPC_W-1:0] OP_BUBBLE = 3'd2;
  localparam logic [OPC_W-1:0] OP_LD     = 3'd3;
  localparam logic [OPC_W-1:0] OP_ST     = 3'd4;
  localparam logic [OPC_W-1:0] OP_CBZ    = 3'd5;
  localparam logic [OPC_W-1:0] OP_ADDI   = 3'd6;
  localparam logic [OPC_W-1:0] OP_ANDI   = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read channel between the fetch unit and memory.
interface instr_fetch_if;
  import leglite_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_data;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/instr_fetch_pc_next.sv
// Next-pc adder: pc + 2, or pc + sign-extended word offset when a branch is taken.
module pc_next
  import leglite_pkg::*;
(
  input  logic [XLEN-1:0]  pc,
  input  logic [OFF_W-1:0] offset,
  input  logic             take_branch,
  output logic [XLEN-1:0]  next_pc
);

  logic [XLEN-1:0] disp_c;

  // Offset counts 16-bit words, so it becomes a byte displacement after the shift.
  always_comb begin
    disp_c  = {{(XLEN-OFF_W){offset[OFF_W-1]}}, offset} << 1;
    next_pc = pc + (take_branch ? disp_c : XLEN'(2));
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch/issue sequencer: requests an instruction at pc, latches it into IR and
// issues it to the decoder, advancing pc unless the downstream stalls.
module instr_fetch
  import leglite_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  instr_fetch_if.master     imem,
  input  logic              stall,
  input  logic              branch,
  input  logic              zero,
  output logic [XLEN-1:0]   instr,
  output logic [OPC_W-1:0]  opcode,
  output logic              instr_valid,
  output logic [XLEN-1:0]   pc
);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc_q, ir_q, next_pc_c;
  logic            req_q;
  logic            ir_load_c, pc_load_c, take_branch_c;

  pc_next u_pc_next (
    .pc          (pc_q),
    .offset      (ir_q[OFF_MSB:OFF_LSB]),
    .take_branch (take_branch_c),
    .next_pc     (next_pc_c)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pc_q  <= RESET_PC;
      ir_q  <= RESET_IR;
      req_q <= 1'b0;
    end else begin
      state <= state_nxt;
      req_q <= (state_nxt == FETCH);
      if (ir_load_c) ir_q <= imem.imem_data;
      if (pc_load_c) pc_q <= next_pc_c;
    end
  end

  // Opcode/instr_valid follow stall within the cycle so a stalled issue is a bubble.
  always_comb begin
    state_nxt     = state;
    ir_load_c     = 1'b0;
    pc_load_c     = 1'b0;
    take_branch_c = 1'b0;
    instr_valid   = 1'b0;
    opcode        = OP_BUBBLE;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (imem.imem_ack) begin
          ir_load_c = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          instr_valid   = 1'b1;
          opcode        = ir_q[OPC_MSB:OPC_LSB];
          pc_load_c     = 1'b1;
          take_branch_c = branch & zero;
          state_nxt     = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr          = ir_q;
  assign pc             = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a memory responder plus address/opcode scoreboards.
module tb_instr_fetch;
  import leglite_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall, branch, zero;
  logic [15:0] instr, pc;
  logic [2:0]  opcode;
  logic        instr_valid;

  instr_fetch_if imem_bus ();

  instr_fetch dut (
    .clock       (clk),
    .reset       (rst_n),
    .imem        (imem_bus),
    .stall       (stall),
    .branch      (branch),
    .zero        (zero),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .pc          (pc)
  );

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_addr_q[$];
  logic [2:0]  exp_op_q[$];
  logic [15:0] ir_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One fetch (ack after dly wait cycles), nst stalled issue cycles, then an issue.
  task automatic fetch_issue(input logic [15:0] d, input int dly, input int nst,
                             input logic br, input logic z);
    logic [15:0] a, off, nxt;
    logic [2:0]  eo;
    if (exp_addr_q.size() == 0) begin
      chk("addr_queue_empty", 16'd0, 16'd1);
      a = 16'hxxxx;
    end else begin
      a = exp_addr_q.pop_front();
    end
    for (int k = 0; k <= dly; k++) begin
      @(negedge clk);
      imem_bus.imem_ack  = (k == dly);
      imem_bus.imem_data = (k == dly) ? d : 16'hDEAD;
      stall = 1'b0; branch = 1'b1; zero = 1'b1;
      #1;
      chk("fetch_req",   16'(imem_bus.imem_req), 16'd1);
      chk("fetch_addr",  imem_bus.imem_addr, a);
      chk("fetch_op",    16'(opcode), 16'(OP_BUBBLE));
      chk("fetch_valid", 16'(instr_valid), 16'd0);
      chk("ir_hold",     instr, ir_m);
    end
    ir_m = d;
    exp_op_q.push_back(d[15:13]);
    for (int s = 0; s < nst; s++) begin
      @(negedge clk);
      imem_bus.imem_ack = 1'b1; imem_bus.imem_data = 16'hFFFF;
      stall = 1'b1; branch = 1'b1; zero = 1'b1;
      #1;
      chk("stall_valid", 16'(instr_valid), 16'd0);
      chk("stall_op",    16'(opcode), 16'(OP_BUBBLE));
      chk("stall_req",   16'(imem_bus.imem_req), 16'd0);
      chk("stall_pc",    pc, a);
      chk("stall_ir",    instr, d);
    end
    @(negedge clk);
    imem_bus.imem_ack = 1'b1; imem_bus.imem_data = 16'hFFFF;
    stall = 1'b0; branch = br; zero = z;
    #1;
    eo = exp_op_q.pop_front();
    chk("issue_valid", 16'(instr_valid), 16'd1);
    chk("issue_op",    16'(opcode), 16'(eo));
    chk("issue_pc",    pc, a);
    chk("issue_req",   16'(imem_bus.imem_req), 16'd0);
    chk("issue_ir",    instr, d);
    off = {{9{d[12]}}, d[12:6]};
    nxt = (br && z) ? a + (off << 1) : a + 16'd2;
    exp_addr_q.push_back(nxt);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req"},   16'(imem_bus.imem_req), 16'd0);
    chk({tag, "_addr"},  imem_bus.imem_addr, 16'h0000);
    chk({tag, "_pc"},    pc, 16'h0000);
    chk({tag, "_ir"},    instr, 16'h4000);
    chk({tag, "_valid"}, 16'(instr_valid), 16'd0);
    chk({tag, "_op"},    16'(opcode), 16'(OP_BUBBLE));
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_req", 16'(imem_bus.imem_req), 16'd0);
    chk("idle_op",  16'(opcode), 16'(OP_BUBBLE));
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0; branch = 1'b0; zero = 1'b0;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_data = 16'h0000;
    ir_m = 16'h4000;
    #12;
    check_reset_values("reset");
    exp_addr_q.push_back(16'h0000);
    release_reset();

    // Zero-wait stream of ADD (all-zero) words walks pc 0,2,..,0x10.
    for (int i = 0; i < 8; i++) fetch_issue(16'h0000, 0, 0, 1'b0, 1'b0);
    // CBZ offset -1 taken at 0x10 -> 0x0E.
    fetch_issue(16'hBFC0, 0, 0, 1'b1, 1'b1);
    // Ack delayed three cycles at 0x0E -> 0x10.
    fetch_issue(16'h0000, 3, 0, 1'b0, 1'b0);
    // CBZ not taken, stalled two cycles with branch/zero high while stalled -> 0x12.
    fetch_issue(16'hBFC0, 0, 2, 1'b1, 1'b0);
    // Most negative offset wraps below zero: 0x12 - 0x80 -> 0xFF92.
    fetch_issue(16'hB000, 0, 0, 1'b1, 1'b1);
    // +54 words -> 0xFFFE.
    fetch_issue(16'hAD80, 1, 0, 1'b1, 1'b1);
    // SUB at 0xFFFE, no branch -> wraps to 0x0000.
    fetch_issue(16'h2000, 0, 1, 1'b0, 1'b1);
    fetch_issue(16'h6000, 0, 0, 1'b0, 1'b0);

    // Reset asserted mid-FETCH with ack pending.
    @(negedge clk);
    imem_bus.imem_ack = 1'b1; imem_bus.imem_data = 16'h1234;
    stall = 1'b0; branch = 1'b0; zero = 1'b0;
    #1;
    chk("prereset_req",  16'(imem_bus.imem_req), 16'd1);
    chk("prereset_addr", imem_bus.imem_addr, 16'h0002);
    #1 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    imem_bus.imem_ack = 1'b0;
    exp_addr_q.delete();
    exp_op_q.delete();
    exp_addr_q.push_back(16'h0000);
    ir_m = 16'h4000;
    release_reset();
    fetch_issue(16'h8000, 0, 0, 1'b0, 1'b0);
    fetch_issue(16'h0000, 0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
